sram_cmd_frontend: RTL and testbench
====================================

Name: sram_cmd_frontend

Overview:
- Upstream stage of the SRAM controller. Turns raw board push-buttons and switch banks into the controller's command inputs.
- Synchronises and debounces the write/read buttons, then converts each press into exactly one single-cycle write or read strobe.
- Presents switch data/address captured on the same cycle as the strobe, and enforces a lockout so the 2-cycle controller FSM (idle -> op -> idle) is never re-triggered mid-operation.
- Runs on the controller's 10 MHz clock.

Parameters:
- DEBOUNCE_CYCLES, 100000: consecutive stable cycles required to accept a button level change (10 ms at 10 MHz). Legal range 1..2^20-1.
- LOCKOUT_CYCLES, 2: idle cycles enforced after each strobe before a new command is accepted. Legal range 1..15.
- DATA_W, 4: switch data width.
- ADDR_W, 4: switch address width.

Ports:
- clk  in  1  system clock, 10 MHz
- rst  in  1  reset, synchronous, active-high
- btn_write  in  1  raw asynchronous write button
- btn_read  in  1  raw asynchronous read button
- sw_data  in  DATA_W  raw data switches
- sw_addr  in  ADDR_W  raw address switches
- write  out  1  one-cycle write strobe to controller
- read  out  1  one-cycle read strobe to controller
- data_in  out  DATA_W  captured data, valid with and after the strobe
- address_in  out  ADDR_W  captured address, valid with and after the strobe
- busy  out  1  high while not in IDLE
- drop_cnt  out  4  saturating count of rejected presses

Behaviour:
- Reset is synchronous and active-high on clk. On reset:
  - write, read, busy = 0; data_in, address_in = 0; drop_cnt = 0.
  - FSM state = IDLE; debounced levels = 0; debounce and lockout counters = 0.
  - Reset asserted mid-command aborts it immediately; a strobe pending that cycle is not issued.
- Button path (per button):
  - 2-FF synchroniser, then debounce counter.
  - Counter increments while the synchronised level differs from the debounced level and clears whenever they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - A rise = debounced 0->1. Only rising edges generate requests; releases are silent.
- Latency: let edge k be the first clock edge that samples the button high, with the button then held steady. The debounced level rises at edge k+DEBOUNCE_CYCLES+1, and the strobe is high for exactly the cycle following edge k+DEBOUNCE_CYCLES+2.
- A button held through reset deassertion is treated as a fresh press: one command is issued after debounce.
- Bounce shorter than DEBOUNCE_CYCLES produces no request.
- Switches are 2-FF synchronised only, not debounced. Capture takes the synchronised value on the IDLE->ISSUE edge.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE: on a write rise, capture switches, set cmd=WR, go to ISSUE. Else on a read rise, capture, set cmd=RD, go to ISSUE. Else stay in IDLE.
  - ISSUE: write = (cmd==WR), read = (cmd==RD), each for exactly 1 cycle. Load the lockout counter with LOCKOUT_CYCLES and go to HOLD.
  - HOLD: decrement the counter; when it reaches 0, go to IDLE. Total time in HOLD = LOCKOUT_CYCLES cycles.
- write and read are decoded from the state register and are never both high.
- Simultaneous write and read rises in IDLE: write wins; the read rise is dropped and counted.
- Any rise arriving in ISSUE or HOLD is dropped, with no queueing; drop_cnt += 1.
- drop_cnt saturates at 15 and clears only on reset.
- data_in and address_in hold their value until the next capture.
- busy = (state != IDLE).

Decomposition:
- Shared package sram_pkg holds:
  - FSM state encoding (IDLE=2'b00, ISSUE=2'b01, HOLD=2'b10);
  - command encoding (CMD_WR=1'b0, CMD_RD=1'b1);
  - default DATA_W/ADDR_W constants, shared with the controller.
- One sub-module, btn_debounce: synchroniser, debounce counter and rise detect, parameterised by DEBOUNCE_CYCLES. Instantiated twice.
- The FSM, capture registers and drop counter stay in the top module.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and LOCKOUT_CYCLES=2.
1. Clean write press: sw_data=4'hA, sw_addr=4'h3, btn_write held 20 cycles from edge k -> write high only in the cycle after edge k+6; data_in=4'hA, address_in=4'h3; busy high 3 cycles; read never asserts.
2. Bounce rejection: btn_read toggles 1,0,1,1,0,1 on consecutive cycles, then stays 0 -> no read strobe, drop_cnt=0, busy stays 0.
3. Simultaneous press: btn_write and btn_read rise on the same edge -> a single write strobe, no read strobe, drop_cnt=1.
4. Press during lockout: write press accepted, then the read button's debounced rise lands in HOLD -> read strobe never issued, drop_cnt increments by 1; a later read press after busy falls -> one read strobe with the new sw_addr captured.
5. Reset mid-operation: rst asserted on the ISSUE cycle edge -> no strobe; the following cycle shows busy=0, data_in=0, drop_cnt=0. A button held through reset -> one strobe exactly 7 cycles after rst deasserts.
6. Saturation: 20 presses forced into HOLD windows -> drop_cnt reads 15 and stays at 15.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared SRAM controller types: FSM/command encodings and default widths.
// Also carries a saturating add used by the drop counter.
package sram_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    HOLD  = 2'b10
  } state_t;

  typedef enum logic {
    CMD_WR = 1'b0,
    CMD_RD = 1'b1
  } cmd_t;

  function automatic logic [3:0] sat_add(
    input logic [3:0] a,
    input logic [1:0] b
  );
    logic [4:0] s;
    s = {1'b0, a} + {3'b000, b};
    return (s > 5'd15) ? 4'hF : s[3:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser + debounce counter.
// Emits a one-cycle rise when the debounced level goes 0->1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int CW = 20;
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      level_d <= level;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/sram_cmd_frontend.sv
// Buttons/switches to one-shot write/read commands for the SRAM
// controller, with a post-command lockout and a dropped-press count.
module sram_cmd_frontend
  import sram_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int LOCKOUT_CYCLES  = 2,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int ADDR_W          = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_write,
  input  logic              btn_read,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [ADDR_W-1:0] sw_addr,
  output logic              write,
  output logic              read,
  output logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] address_in,
  output logic              busy,
  output logic [3:0]        drop_cnt
);

  localparam logic [3:0] LOCK_LD = 4'(LOCKOUT_CYCLES);

  logic              wr_rise;
  logic              rd_rise;
  logic [1:0]        n_rise;
  logic [DATA_W-1:0] sd1;
  logic [DATA_W-1:0] sd2;
  logic [ADDR_W-1:0] sa1;
  logic [ADDR_W-1:0] sa2;
  state_t            state;
  cmd_t              cmd;
  logic [3:0]        lock;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_wr (
    .clk (clk),
    .rst (rst),
    .btn (btn_write),
    .rise(wr_rise)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_rd (
    .clk (clk),
    .rst (rst),
    .btn (btn_read),
    .rise(rd_rise)
  );

  assign n_rise = {1'b0, wr_rise} + {1'b0, rd_rise};

  always_ff @(posedge clk) begin
    if (rst) begin
      sd1        <= '0;
      sd2        <= '0;
      sa1        <= '0;
      sa2        <= '0;
      state      <= IDLE;
      cmd        <= CMD_WR;
      lock       <= '0;
      data_in    <= '0;
      address_in <= '0;
      drop_cnt   <= '0;
    end else begin
      sd1 <= sw_data;
      sd2 <= sd1;
      sa1 <= sw_addr;
      sa2 <= sa1;
      unique case (state)
        IDLE: begin
          if (wr_rise) begin
            state      <= ISSUE;
            cmd        <= CMD_WR;
            data_in    <= sd2;
            address_in <= sa2;
            // write wins a tie; the read press is lost
            if (rd_rise)
              drop_cnt <= sat_add(drop_cnt, 2'd1);
          end else if (rd_rise) begin
            state      <= ISSUE;
            cmd        <= CMD_RD;
            data_in    <= sd2;
            address_in <= sa2;
          end
        end
        ISSUE: begin
          lock     <= LOCK_LD;
          state    <= HOLD;
          drop_cnt <= sat_add(drop_cnt, n_rise);
        end
        HOLD: begin
          lock     <= lock - 4'd1;
          drop_cnt <= sat_add(drop_cnt, n_rise);
          if (lock == 4'd1)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign write = (state == ISSUE) && (cmd == CMD_WR);
  assign read  = (state == ISSUE) && (cmd == CMD_RD);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_sram_cmd_frontend.sv
// Directed bench for sram_cmd_frontend with a timeline model
// checked every cycle plus hand-computed literal expectations.
module tb_sram_cmd_frontend;

  localparam int D = 4;
  localparam int L = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_write = 1'b0;
  logic       btn_read = 1'b0;
  logic [3:0] sw_data = 4'h0;
  logic [3:0] sw_addr = 4'h0;
  logic       write;
  logic       read;
  logic [3:0] data_in;
  logic [3:0] address_in;
  logic       busy;
  logic [3:0] drop_cnt;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  sram_cmd_frontend #(
    .DEBOUNCE_CYCLES(D),
    .LOCKOUT_CYCLES (L),
    .DATA_W         (4),
    .ADDR_W         (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_write (btn_write),
    .btn_read  (btn_read),
    .sw_data   (sw_data),
    .sw_addr   (sw_addr),
    .write     (write),
    .read      (read),
    .data_in   (data_in),
    .address_in(address_in),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #50 clk = ~clk;

  task automatic chk(
    input string name,
    input int    act,
    input int    exp
  );
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  // Model: inputs seen by the debouncer lag the pins by two
  // edges; a level is accepted after D consecutive differing
  // samples; an accepted press gives one strobe cycle followed
  // by L lockout cycles.
  bit m_ok = 0;
  bit p1[2], p2[2];
  int deb[2], deb_old[2], run[2];
  int sd1, sd2, sa1, sa2;
  int left, kind, md, ma, drops;

  task automatic model_step();
    bit b[2];
    bit r0, r1;
    b[0] = btn_write;
    b[1] = btn_read;
    if (rst) begin
      m_ok = 1;
      for (int i = 0; i < 2; i++) begin
        p1[i] = 0; p2[i] = 0;
        deb[i] = 0; deb_old[i] = 0; run[i] = 0;
      end
      sd1 = 0; sd2 = 0; sa1 = 0; sa2 = 0;
      left = 0; kind = 0; md = 0; ma = 0; drops = 0;
    end else begin
      r0 = (deb[0] == 1) && (deb_old[0] == 0);
      r1 = (deb[1] == 1) && (deb_old[1] == 0);
      if (left == 0) begin
        if (r0 || r1) begin
          left = 1 + L;
          kind = r0 ? 0 : 1;
          md = sd2;
          ma = sa2;
          if (r0 && r1) drops++;
        end
      end else begin
        left--;
        drops += int'(r0) + int'(r1);
      end
      if (drops > 15) drops = 15;
      for (int i = 0; i < 2; i++) begin
        deb_old[i] = deb[i];
        if (int'(p2[i]) != deb[i]) begin
          run[i]++;
          if (run[i] == D) begin
            deb[i] = p2[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
        p2[i] = p1[i];
        p1[i] = b[i];
      end
      sd2 = sd1; sd1 = sw_data;
      sa2 = sa1; sa1 = sw_addr;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      chk("m_write", write,
          (left == 1 + L && kind == 0) ? 1 : 0);
      chk("m_read", read,
          (left == 1 + L && kind == 1) ? 1 : 0);
      chk("m_busy", busy, (left > 0) ? 1 : 0);
      chk("m_data", data_in, md);
      chk("m_addr", address_in, ma);
      chk("m_drop", drop_cnt, drops);
      if (write === 1'b1) wr_cnt++;
      if (read === 1'b1) rd_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit bseq[6];
    bseq = '{1, 0, 1, 1, 0, 1};
    tick(3);
    chk("rst_write", write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_in, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    tick(2);

    // clean write press
    sw_data = 4'hA;
    sw_addr = 4'h3;
    btn_write = 1'b1;
    tick(6);
    chk("s1_pre", write, 0);
    tick(1);
    chk("s1_write", write, 1);
    chk("s1_data", data_in, 4'hA);
    chk("s1_addr", address_in, 4'h3);
    chk("s1_busy0", busy, 1);
    tick(1);
    chk("s1_wr_off", write, 0);
    chk("s1_busy1", busy, 1);
    tick(1);
    chk("s1_busy2", busy, 1);
    tick(1);
    chk("s1_idle", busy, 0);
    tick(11);
    btn_write = 1'b0;
    tick(12);
    chk("s1_wrs", wr_cnt, 1);
    chk("s1_rds", rd_cnt, 0);

    // bounce rejection
    for (int i = 0; i < 6; i++) begin
      btn_read = bseq[i];
      tick(1);
    end
    btn_read = 1'b0;
    tick(15);
    chk("s2_rds", rd_cnt, 0);
    chk("s2_drop", drop_cnt, 0);

    // simultaneous press
    btn_write = 1'b1;
    btn_read = 1'b1;
    tick(10);
    btn_write = 1'b0;
    btn_read = 1'b0;
    tick(12);
    chk("s3_wrs", wr_cnt, 2);
    chk("s3_rds", rd_cnt, 0);
    chk("s3_drop", drop_cnt, 1);

    // read lands in lockout, then a clean read
    btn_write = 1'b1;
    tick(2);
    btn_read = 1'b1;
    tick(10);
    btn_write = 1'b0;
    btn_read = 1'b0;
    tick(12);
    chk("s4_drop", drop_cnt, 2);
    chk("s4_rds0", rd_cnt, 0);
    sw_addr = 4'h5;
    btn_read = 1'b1;
    tick(7);
    chk("s4_read", read, 1);
    chk("s4_addr", address_in, 4'h5);
    tick(10);
    btn_read = 1'b0;
    tick(12);
    chk("s4_rds1", rd_cnt, 1);

    // reset on the issue edge, button held through reset
    btn_write = 1'b1;
    tick(6);
    rst = 1'b1;
    tick(1);
    chk("s5_write", write, 0);
    chk("s5_busy", busy, 0);
    chk("s5_data", data_in, 0);
    chk("s5_drop", drop_cnt, 0);
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("s5_pre", write, 0);
    tick(1);
    chk("s5_strobe", write, 1);
    tick(5);
    btn_write = 1'b0;
    tick(12);

    // drop counter saturation
    for (int i = 0; i < 20; i++) begin
      btn_write = 1'b1;
      tick(2);
      btn_read = 1'b1;
      tick(10);
      btn_write = 1'b0;
      btn_read = 1'b0;
      tick(12);
    end
    chk("s6_sat", drop_cnt, 15);
    btn_write = 1'b1;
    tick(2);
    btn_read = 1'b1;
    tick(10);
    btn_write = 1'b0;
    btn_read = 1'b0;
    tick(12);
    chk("s6_hold", drop_cnt, 15);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
